output_conditioner: RTL and testbench

- Output-side counterpart of the input conditioning path. Accepts one-cycle edge-request pulses from internal logic and drives a clean registered level to a pin.
- Guarantees a minimum dwell time between output transitions, so the pin never glitches faster than external hardware can tolerate.
- Holds one pending request, with last-request-wins semantics.
- Sits between core logic (LED/SPI/GPIO drivers) and the output pad.

---
 rtl/output_conditioner_pkg.sv | 29 ++
 rtl/output_conditioner_dwell_timer.sv | 32 +++
 rtl/output_conditioner.sv | 116 +++++++++++
 tb/tb_output_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/output_conditioner_pkg.sv
// Shared definitions for output-side conditioning blocks.
// State encodings and request decode reused by future pad drivers.
package output_conditioner_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_DWELL = 1'b1;

    typedef enum logic {
        IDLE  = STATE_IDLE,
        DWELL = STATE_DWELL
    } state_t;

    typedef struct packed {
        logic valid;
        logic level;
    } request_t;

    // Both or neither edge asserted collapses to "no request".
    function automatic request_t decode_request(
        input logic positiveedge,
        input logic negativeedge
    );
        request_t r;
        r.valid = positiveedge ^ negativeedge;
        r.level = positiveedge;
        return r;
    endfunction

endpackage

// File: rtl/output_conditioner_dwell_timer.sv
// Dwell counter: clear to 0, load to 1, or count up.
// done flags the final cycle of a dwell (count == holdtime).
module dwell_timer #(
    parameter int counterwidth = 3,
    parameter int holdtime     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic done
);

    logic [counterwidth-1:0] count;

    // Counter is re-seeded at every dwell boundary, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= counterwidth'(1);
        end else if (enable) begin
            count <= count + counterwidth'(1);
        end
    end

    assign done = (count == counterwidth'(holdtime));

endmodule

// File: rtl/output_conditioner.sv
// Edge-request to pad-level conditioner with minimum dwell time.
// Holds one pending request; the latest request wins.
module output_conditioner
    import output_conditioner_pkg::*;
#(
    parameter int counterwidth = 3,
    parameter int holdtime     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic positiveedge,
    input  logic negativeedge,
    output logic outsignal,
    output logic busy,
    output logic overrun
);

    state_t   state;
    state_t   state_next;
    request_t req;
    logic     out_next;
    logic     pend_valid;
    logic     pend_valid_next;
    logic     pend_level;
    logic     pend_level_next;
    logic     overrun_next;
    logic     eff_valid;
    logic     eff_level;
    logic     timer_clear;
    logic     timer_load;
    logic     timer_enable;
    logic     timer_done;

    assign req = decode_request(positiveedge, negativeedge);

    dwell_timer #(
        .counterwidth(counterwidth),
        .holdtime    (holdtime)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .load  (timer_load),
        .enable(timer_enable),
        .done  (timer_done)
    );

    // Register FSM state, pad level, pending slot and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            outsignal  <= 1'b0;
            pend_valid <= 1'b0;
            pend_level <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            outsignal  <= out_next;
            pend_valid <= pend_valid_next;
            pend_level <= pend_level_next;
            overrun    <= overrun_next;
        end
    end

    // Next-state, pending-slot and timer control decode.
    always_comb begin
        state_next      = state;
        out_next        = outsignal;
        pend_valid_next = pend_valid;
        pend_level_next = pend_level;
        overrun_next    = 1'b0;
        timer_clear     = 1'b0;
        timer_load      = 1'b0;
        timer_enable    = 1'b0;
        eff_valid       = req.valid | pend_valid;
        eff_level       = req.valid ? req.level : pend_level;
        unique case (state)
            IDLE: begin
                if (req.valid && (req.level != outsignal)) begin
                    out_next   = req.level;
                    state_next = DWELL;
                    timer_load = 1'b1;
                end
            end
            DWELL: begin
                if (req.valid && pend_valid && (req.level != pend_level)) begin
                    overrun_next = 1'b1;
                end
                if (!timer_done) begin
                    timer_enable = 1'b1;
                    if (req.valid) begin
                        pend_valid_next = 1'b1;
                        pend_level_next = req.level;
                    end
                end else begin
                    pend_valid_next = 1'b0;
                    pend_level_next = 1'b0;
                    if (eff_valid && (eff_level != outsignal)) begin
                        out_next   = eff_level;
                        timer_load = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        timer_clear = 1'b1;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                timer_clear = 1'b1;
            end
        endcase
    end

    assign busy = (state == DWELL);

endmodule

// File: tb/tb_output_conditioner.sv
// Directed bench for output_conditioner (holdtime 3 and holdtime 1).
// Table-driven main sequence plus hand-written corner cases.
module tb_output_conditioner;

    typedef struct {
        logic p;
        logic n;
        logic o;
        logic b;
        logic v;
    } vec_t;

    logic clk;
    logic reset;
    logic pos3, neg3, out3, busy3, ovr3;
    logic pos1, neg1, out1, busy1, ovr1;

    int n_checks;
    int n_fail;

    vec_t tbl[$];

    output_conditioner #(.counterwidth(3), .holdtime(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .positiveedge(pos3),
        .negativeedge(neg3),
        .outsignal   (out3),
        .busy        (busy3),
        .overrun     (ovr3)
    );

    output_conditioner #(.counterwidth(2), .holdtime(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .positiveedge(pos1),
        .negativeedge(neg1),
        .outsignal   (out1),
        .busy        (busy1),
        .overrun     (ovr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one request cycle, then check outputs just after the edge.
    task automatic apply(input bit sel, input logic p, input logic n,
                         input logic eo, input logic eb, input logic ev,
                         input string nm);
        if (sel) begin
            pos1 = p;
            neg1 = n;
        end else begin
            pos3 = p;
            neg3 = n;
        end
        @(posedge clk);
        #1;
        pos3 = 1'b0;
        neg3 = 1'b0;
        pos1 = 1'b0;
        neg1 = 1'b0;
        if (sel) begin
            chk({nm, ".out"}, out1, eo);
            chk({nm, ".busy"}, busy1, eb);
            chk({nm, ".overrun"}, ovr1, ev);
        end else begin
            chk({nm, ".out"}, out3, eo);
            chk({nm, ".busy"}, busy3, eb);
            chk({nm, ".overrun"}, ovr3, ev);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        pos3 = 1'b0;
        neg3 = 1'b0;
        pos1 = 1'b0;
        neg1 = 1'b0;

        //            p  n  out busy ovr
        tbl.push_back('{1, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 0});
        tbl.push_back('{1, 0, 1, 1, 1});
        tbl.push_back('{0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0});

        #12;
        chk("reset.out3", out3, 1'b0);
        chk("reset.busy3", busy3, 1'b0);
        chk("reset.overrun3", ovr3, 1'b0);
        chk("reset.out1", out1, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].p, tbl[i].n, tbl[i].o, tbl[i].b, tbl[i].v,
                  $sformatf("vec%0d", i));
        end

        // holdtime 1: opposite requests every cycle toggle every edge
        for (int i = 0; i < 8; i++) begin
            logic lp;
            lp = (i % 2 == 0);
            apply(1'b1, lp, ~lp, lp, 1'b1, 1'b0, $sformatf("h1_toggle%0d", i));
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "h1_settle");

        // reset mid-dwell with pending request and live overrun
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rst_pre0");
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_pre1");
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_pre2");
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_pre3");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rst_go");
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "rst_pend");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "rst_ovr");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async.out", out3, 1'b0);
        chk("rst_async.busy", busy3, 1'b0);
        chk("rst_async.overrun", ovr3, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("rst_after%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
